// File: rtl/traffic_light_monitor.sv
// Passive monitor for the four-approach traffic light bus: decodes the lamp codes into a phase,
// checks phase order and dwell times, latches sticky error flags and counts completed rotations.
module traffic_light_monitor #(
    parameter int GREEN_TIME  = 10,
    parameter int YELLOW_TIME = 5,
    parameter int RED_TIME    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] ns_light,
    input  logic [2:0] sn_light,
    input  logic [2:0] ew_light,
    input  logic [2:0] we_light,
    input  logic       err_clear,
    output logic [2:0] phase,
    output logic       in_sync,
    output logic       conflict_err,
    output logic       seq_err,
    output logic       timing_err,
    output logic [7:0] cycle_count
);

    typedef enum logic [1:0] {
        ST_START  = 2'd0,
        ST_TRACK  = 2'd1,
        ST_RESYNC = 2'd2
    } state_t;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    localparam logic [2:0] PH_NS_G    = 3'd0;
    localparam logic [2:0] PH_NS_Y    = 3'd1;
    localparam logic [2:0] PH_ALL_RED = 3'd2;
    localparam logic [2:0] PH_EW_G    = 3'd3;
    localparam logic [2:0] PH_EW_Y    = 3'd4;
    localparam logic [2:0] PH_ILLEGAL = 3'd7;

    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;

    function automatic logic is_onehot3(input logic [2:0] code);
        return (code == LAMP_RED) || (code == LAMP_YELLOW) || (code == LAMP_GREEN);
    endfunction

    // A timer loaded with N holds its phase for N+1 samples.
    function automatic logic [5:0] expected_dwell(input logic [2:0] ph);
        case (ph)
            PH_NS_G, PH_EW_G: return 6'(GREEN_TIME + 1);
            PH_NS_Y, PH_EW_Y: return 6'(YELLOW_TIME + 1);
            PH_ALL_RED:       return 6'(RED_TIME + 1);
            default:          return 6'd0;
        endcase
    endfunction

    state_t      state_r, state_s;
    logic [2:0]  phase_r, cur_s;
    logic [5:0]  dwell_r, dwell_s, dwell_inc_s, exp_prev_s;
    logic        last_dir_r, last_dir_s;
    logic [7:0]  cycle_count_r, cycle_count_s;
    logic        in_sync_r;
    logic        conflict_err_r, seq_err_r, timing_err_r;
    logic        set_conflict_s, set_seq_s, set_timing_s;

    // Decode the sampled lamp bus into a phase code.
    always_comb begin
        cur_s = PH_ILLEGAL;
        if ((ns_light != sn_light) || (ew_light != we_light) ||
            !is_onehot3(ns_light) || !is_onehot3(ew_light)) begin
            cur_s = PH_ILLEGAL;
        end else if ((ns_light == LAMP_RED) && (ew_light == LAMP_RED)) begin
            cur_s = PH_ALL_RED;
        end else if (ew_light == LAMP_RED) begin
            cur_s = (ns_light == LAMP_GREEN) ? PH_NS_G : PH_NS_Y;
        end else if (ns_light == LAMP_RED) begin
            cur_s = (ew_light == LAMP_GREEN) ? PH_EW_G : PH_EW_Y;
        end else begin
            cur_s = PH_ILLEGAL;
        end
    end

    // Tracking FSM: next state, dwell, direction memory, rotation count and flag set requests.
    always_comb begin
        dwell_inc_s    = (dwell_r == 6'd63) ? 6'd63 : (dwell_r + 6'd1);
        dwell_s        = (cur_s == phase_r) ? dwell_inc_s : 6'd1;
        exp_prev_s     = expected_dwell(phase_r);
        state_s        = state_r;
        last_dir_s     = last_dir_r;
        cycle_count_s  = cycle_count_r;
        set_conflict_s = 1'b0;
        set_seq_s      = 1'b0;
        set_timing_s   = 1'b0;
        if (cur_s == PH_ILLEGAL) begin
            set_conflict_s = 1'b1;
            state_s        = ST_RESYNC;
        end else begin
            case (state_r)
                ST_START: begin
                    if (cur_s == PH_NS_G) begin
                        state_s = ST_TRACK;
                    end else begin
                        set_seq_s = 1'b1;
                        state_s   = ST_RESYNC;
                    end
                end
                ST_TRACK: begin
                    if (cur_s == phase_r) begin
                        // Overstay is flagged only on the first sample past the expected dwell.
                        set_timing_s = (dwell_r == exp_prev_s);
                    end else begin
                        set_timing_s = (dwell_r != exp_prev_s);
                        case ({phase_r, cur_s})
                            {PH_NS_G, PH_NS_Y}, {PH_EW_G, PH_EW_Y}: state_s = ST_TRACK;
                            {PH_NS_Y, PH_ALL_RED}: last_dir_s = DIR_NS;
                            {PH_EW_Y, PH_ALL_RED}: last_dir_s = DIR_EW;
                            {PH_ALL_RED, PH_EW_G}: begin
                                if (last_dir_r == DIR_NS) begin
                                    state_s = ST_TRACK;
                                end else begin
                                    set_seq_s = 1'b1;
                                    state_s   = ST_RESYNC;
                                end
                            end
                            {PH_ALL_RED, PH_NS_G}: begin
                                if (last_dir_r == DIR_EW) begin
                                    cycle_count_s = cycle_count_r + 8'd1;
                                end else begin
                                    set_seq_s = 1'b1;
                                    state_s   = ST_RESYNC;
                                end
                            end
                            default: begin
                                set_seq_s = 1'b1;
                                state_s   = ST_RESYNC;
                            end
                        endcase
                    end
                end
                ST_RESYNC: begin
                    if ((phase_r == PH_ALL_RED) && (cur_s == PH_NS_G)) begin
                        state_s    = ST_TRACK;
                        last_dir_s = DIR_EW;
                    end else if ((phase_r == PH_ALL_RED) && (cur_s == PH_EW_G)) begin
                        state_s    = ST_TRACK;
                        last_dir_s = DIR_NS;
                    end else begin
                        state_s = ST_RESYNC;
                    end
                end
                default: state_s = ST_RESYNC;
            endcase
        end
    end

    // State and output registers; a set request outranks err_clear on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= ST_START;
            phase_r        <= PH_ALL_RED;
            dwell_r        <= 6'd0;
            last_dir_r     <= DIR_EW;
            cycle_count_r  <= 8'd0;
            in_sync_r      <= 1'b0;
            conflict_err_r <= 1'b0;
            seq_err_r      <= 1'b0;
            timing_err_r   <= 1'b0;
        end else begin
            state_r        <= state_s;
            phase_r        <= cur_s;
            dwell_r        <= dwell_s;
            last_dir_r     <= last_dir_s;
            cycle_count_r  <= cycle_count_s;
            in_sync_r      <= (state_s == ST_TRACK);
            conflict_err_r <= set_conflict_s | (conflict_err_r & ~err_clear);
            seq_err_r      <= set_seq_s | (seq_err_r & ~err_clear);
            timing_err_r   <= set_timing_s | (timing_err_r & ~err_clear);
        end
    end

    assign phase        = phase_r;
    assign in_sync      = in_sync_r;
    assign conflict_err = conflict_err_r;
    assign seq_err      = seq_err_r;
    assign timing_err   = timing_err_r;
    assign cycle_count  = cycle_count_r;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: each task drives lamp sequences and compares the
// packed status {phase, in_sync, conflict_err, seq_err, timing_err, cycle_count} to hand values.
module tb_traffic_light_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic       clk;
    logic       reset;
    logic [2:0] ns_light, sn_light, ew_light, we_light;
    logic       err_clear;
    logic [2:0] phase;
    logic       in_sync, conflict_err, seq_err, timing_err;
    logic [7:0] cycle_count;

    int          n_checks;
    int          n_fail;
    logic [14:0] exp_v;

    traffic_light_monitor #(.GREEN_TIME(10), .YELLOW_TIME(5), .RED_TIME(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .ns_light     (ns_light),
        .sn_light     (sn_light),
        .ew_light     (ew_light),
        .we_light     (we_light),
        .err_clear    (err_clear),
        .phase        (phase),
        .in_sync      (in_sync),
        .conflict_err (conflict_err),
        .seq_err      (seq_err),
        .timing_err   (timing_err),
        .cycle_count  (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] ex(input logic [2:0] ph, input logic sync, input logic c,
                                       input logic s, input logic t, input logic [7:0] cc);
        return {ph, sync, c, s, t, cc};
    endfunction

    function automatic logic [14:0] st();
        return {phase, in_sync, conflict_err, seq_err, timing_err, cycle_count};
    endfunction

    // Hold the NS pair at ns_c and the EW pair at ew_c for n samples; returns 1 time unit after the last edge.
    task automatic drive(input logic [2:0] ns_c, input logic [2:0] ew_c, input int n);
        ns_light = ns_c;
        sn_light = ns_c;
        ew_light = ew_c;
        we_light = ew_c;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        err_clear = 1'b0;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; err_clear = 1'b0;
        ns_light = G; sn_light = G; ew_light = R; we_light = R;
        repeat (2) @(posedge clk);
        #1;
        exp_v = ex(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        n_checks++;
        if (st() !== exp_v) begin n_fail++; $display("FAIL reset_values: got %h expected %h", st(), exp_v); end
        #1 reset = 1'b0;
        drive(G, R, 3);
        exp_v = ex(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        n_checks++;
        if (st() !== exp_v) begin n_fail++; $display("FAIL first_ns_green: got %h expected %h", st(), exp_v); end
        reset = 1'b1;
        #2;
        exp_v = ex(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        n_checks++;
        if (st() !== exp_v) begin n_fail++; $display("FAIL async_reset: got %h expected %h", st(), exp_v); end
        #2 reset = 1'b0;
    endtask

    task automatic test_clean_rotation();
        do_reset();
        drive(G, R, 11);
        exp_v = ex(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        n_checks++;
        if (st() !== exp_v) begin n_fail++; $display("FAIL rot_ns_green: got %h expected %h", st(), exp_v); end
        drive(Y, R, 6);
        exp_v = ex(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        n_checks++;
        if (st() !== exp_v) begin n_fail++; $display("FAIL rot_ns_yellow: got %h expected %h", st(), exp_v); end
        drive(R, R, 4);
        exp_v = ex(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        n_checks++;
        if (st() !== exp_v) begin n_fail++; $display("FAIL rot_all_red1: got %h expected %h", st(), exp_v); end
        drive(R, G, 11);
        exp_v = ex(3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        n_checks++;
        if (st() !== exp_v) begin n_fail++; $display("FAIL rot_ew_green: got %h expected %h", st(), exp_v); end
        drive(R, Y, 6);
        exp_v = ex(3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        n_checks++;
        if (st() !== exp_v) begin n_fail++; $display("FAIL rot_ew_yellow: got %h expected %h", st(), exp_v); end
        drive(R, R, 4);
        exp_v = ex(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        n_checks++;
        if (st() !== exp_v) begin n_fail++; $display("FAIL rot_all_red2: got %h expected %h", st(), exp_v); end
        drive(G, R, 1);
        exp_v = ex(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
        n_checks++;
        if (st() !== exp_v) begin n_fail++; $display("FAIL rot_count: got %h expected %h", st(), exp_v); end
    endtask

    task automatic test_conflict();
        do_reset();
        drive(G, R, 5);
        drive(G, G, 1);
        exp_v = ex(3'd7, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        n_checks++;
        if (st() !== exp_v) begin n_fail++; $display("FAIL conflict_set: got %h expected %h", st(), exp_v); end
        drive(R, R, 4);
        exp_v = ex(3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        n_checks++;
        if (st() !== exp_v) begin n_fail++; $display("FAIL conflict_resync_red: got %h expected %h", st(), exp_v); end
        drive(R, G, 1);
        exp_v = ex(3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        n_checks++;
        if (st() !== exp_v) begin n_fail++; $display("FAIL conflict_resync_ew: got %h expected %h", st(), exp_v); end
        err_clear = 1'b1;
        drive(R, G, 1);
        err_clear = 1'b0;
        exp_v = ex(3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        n_checks++;
        if (st() !== exp_v) begin n_fail++; $display("FAIL conflict_clear: got %h expected %h", st(), exp_v); end
    endtask

    task automatic test_timing();
        do_reset();
        drive(G, R, 11);
        drive(Y, R, 5);
        exp_v = ex(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        n_checks++;
        if (st() !== exp_v) begin n_fail++; $display("FAIL short_yellow_pre: got %h expected %h", st(), exp_v); end
        drive(R, R, 1);
        exp_v = ex(3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
        n_checks++;
        if (st() !== exp_v) begin n_fail++; $display("FAIL short_yellow: got %h expected %h", st(), exp_v); end
        do_reset();
        drive(G, R, 11);
        exp_v = ex(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        n_checks++;
        if (st() !== exp_v) begin n_fail++; $display("FAIL overstay_pre: got %h expected %h", st(), exp_v); end
        drive(G, R, 1);
        exp_v = ex(3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
        n_checks++;
        if (st() !== exp_v) begin n_fail++; $display("FAIL overstay_12th: got %h expected %h", st(), exp_v); end
        err_clear = 1'b1;
        drive(G, R, 1);
        err_clear = 1'b0;
        drive(G, R, 1);
        exp_v = ex(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        n_checks++;
        if (st() !== exp_v) begin n_fail++; $display("FAIL overstay_once: got %h expected %h", st(), exp_v); end
    endtask

    task automatic test_bad_order();
        do_reset();
        drive(G, R, 11);
        drive(Y, R, 6);
        drive(R, R, 4);
        drive(G, R, 1);
        exp_v = ex(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        n_checks++;
        if (st() !== exp_v) begin n_fail++; $display("FAIL bad_order_ns_again: got %h expected %h", st(), exp_v); end
        do_reset();
        drive(G, R, 11);
        drive(R, G, 1);
        exp_v = ex(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        n_checks++;
        if (st() !== exp_v) begin n_fail++; $display("FAIL bad_order_g_to_g: got %h expected %h", st(), exp_v); end
    endtask

    task automatic test_mismatch_clear();
        do_reset();
        drive(G, R, 3);
        ns_light = G; sn_light = Y; ew_light = R; we_light = R;
        @(posedge clk);
        #1;
        exp_v = ex(3'd7, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        n_checks++;
        if (st() !== exp_v) begin n_fail++; $display("FAIL pair_mismatch: got %h expected %h", st(), exp_v); end
        drive(R, R, 4);
        drive(G, R, 1);
        exp_v = ex(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        n_checks++;
        if (st() !== exp_v) begin n_fail++; $display("FAIL resync_ns_no_count: got %h expected %h", st(), exp_v); end
        drive(G, R, 2);
        err_clear = 1'b1;
        drive(Y, R, 1);
        err_clear = 1'b0;
        exp_v = ex(3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
        n_checks++;
        if (st() !== exp_v) begin n_fail++; $display("FAIL set_beats_clear: got %h expected %h", st(), exp_v); end
    endtask

    task automatic test_reset_midop();
        do_reset();
        drive(G, R, 11);
        drive(Y, R, 6);
        drive(R, R, 4);
        drive(R, G, 11);
        drive(R, Y, 6);
        drive(R, R, 4);
        drive(G, R, 5);
        drive(R, G, 1);
        exp_v = ex(3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1);
        n_checks++;
        if (st() !== exp_v) begin n_fail++; $display("FAIL seq_and_timing_same_edge: got %h expected %h", st(), exp_v); end
        drive(G, G, 1);
        drive(R, R, 4);
        drive(R, G, 3);
        exp_v = ex(3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1);
        n_checks++;
        if (st() !== exp_v) begin n_fail++; $display("FAIL all_flags_sticky: got %h expected %h", st(), exp_v); end
        reset = 1'b1;
        #2;
        exp_v = ex(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        n_checks++;
        if (st() !== exp_v) begin n_fail++; $display("FAIL midop_async_reset: got %h expected %h", st(), exp_v); end
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        exp_v = ex(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        n_checks++;
        if (st() !== exp_v) begin n_fail++; $display("FAIL start_not_ns_green: got %h expected %h", st(), exp_v); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_clean_rotation();
        test_conflict();
        test_timing();
        test_bad_order();
        test_mismatch_clear();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
